// File: rtl/frame_sync_fifo_if.sv
// Write/read bundle shared by frame_sync_fifo and whatever drives it.
// The slave side is the FIFO itself; the master side is the frame producer/consumer.
interface frame_sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 512
);
    localparam int AW_C = $clog2(FIFO_DEPTH);

    logic                  WrEn;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  WrCommit;
    logic                  WrDiscard;
    logic                  WrFull;
    logic                  WrAFull;
    logic [AW_C:0]         WrDNum;
    logic                  WrOvfl;
    logic                  FrmDrop;
    logic                  RdEn;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdEmpty;
    logic                  RdAEmpty;
    logic [AW_C:0]         RdDNum;
    logic                  RdUdfl;

    modport master (
        output WrEn, WrData, WrCommit, WrDiscard, RdEn,
        input  WrFull, WrAFull, WrDNum, WrOvfl, FrmDrop,
        input  RdData, RdEmpty, RdAEmpty, RdDNum, RdUdfl
    );

    modport slave (
        input  WrEn, WrData, WrCommit, WrDiscard, RdEn,
        output WrFull, WrAFull, WrDNum, WrOvfl, FrmDrop,
        output RdData, RdEmpty, RdAEmpty, RdDNum, RdUdfl
    );
endinterface

// File: rtl/frame_sync_fifo.sv
// Single-clock frame FIFO: words become readable only on commit, and a discarded
// or overflowed frame is rolled back to the last commit point.
module frame_sync_fifo #(
    parameter string FIFO_MODE  = "Normal",
    parameter int    DATA_WIDTH = 8,
    parameter int    FIFO_DEPTH = 512,
    parameter int    AFULL_GAP  = 16,
    parameter int    AEMPTY_TH  = 4,
    parameter int    AW_C       = $clog2(FIFO_DEPTH)
) (
    input  logic             SysClk,
    input  logic             Reset_N,
    frame_sync_fifo_if.slave bus
);
    localparam bit            SHOW_AHEAD = (FIFO_MODE == "ShowAhead");
    localparam int            PW         = AW_C + 1;
    localparam logic [PW-1:0] DEPTH_C    = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] AFULL_C    = PW'(AFULL_GAP);
    localparam logic [PW-1:0] AEMPTY_C   = PW'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  frm_err_q, frm_err_d;
    logic                  hvld_q, hvld_d;
    logic                  ovfl_q, ovfl_d;
    logic                  drop_q, drop_d;
    logic                  udfl_q, udfl_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [PW-1:0]         head_cnt, wr_dnum, rd_dnum, free_cnt, wr_ptr_inc;
    logic                  wr_full, rd_empty, mem_avail;
    logic                  wr_accept, wr_reject, rollback, commit, pop, fetch;

    // rd_ptr marks the next word not yet pulled out of memory; in ShowAhead mode
    // the head register still holds one word, so it is added back into both counts.
    always_comb begin
        head_cnt   = {{AW_C{1'b0}}, hvld_q};
        wr_dnum    = wr_ptr_q - rd_ptr_q + head_cnt;
        rd_dnum    = cm_ptr_q - rd_ptr_q + head_cnt;
        free_cnt   = DEPTH_C - wr_dnum;
        wr_full    = (wr_dnum == DEPTH_C);
        mem_avail  = (cm_ptr_q != rd_ptr_q);
        rd_empty   = SHOW_AHEAD ? ~hvld_q : ~mem_avail;

        wr_accept  = bus.WrEn & ~wr_full;
        wr_reject  = bus.WrEn & wr_full;
        wr_ptr_inc = wr_ptr_q + PW'(wr_accept);
        rollback   = bus.WrDiscard | (bus.WrCommit & (frm_err_q | wr_reject));
        commit     = bus.WrCommit & ~rollback;

        pop        = bus.RdEn & ~rd_empty;
        fetch      = SHOW_AHEAD ? (mem_avail & (~hvld_q | pop)) : pop;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_inc;
        cm_ptr_d  = cm_ptr_q;
        frm_err_d = frm_err_q | wr_reject;
        if (rollback) begin
            wr_ptr_d  = cm_ptr_q;
            frm_err_d = 1'b0;
        end else if (commit) begin
            cm_ptr_d  = wr_ptr_inc;
            frm_err_d = 1'b0;
        end

        rd_ptr_d  = rd_ptr_q + PW'(fetch);
        rd_data_d = rd_data_q;
        if (fetch) begin
            rd_data_d = mem_q[rd_ptr_q[AW_C-1:0]];
        end
        hvld_d = SHOW_AHEAD & (fetch | (hvld_q & ~pop));

        ovfl_d = wr_reject;
        drop_d = rollback;
        udfl_d = bus.RdEn & rd_empty;
    end

    always_ff @(posedge SysClk or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_ptr_q  <= '0;
            cm_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            frm_err_q <= 1'b0;
            hvld_q    <= 1'b0;
            ovfl_q    <= 1'b0;
            drop_q    <= 1'b0;
            udfl_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            cm_ptr_q  <= cm_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            frm_err_q <= frm_err_d;
            hvld_q    <= hvld_d;
            ovfl_q    <= ovfl_d;
            drop_q    <= drop_d;
            udfl_q    <= udfl_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge SysClk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[AW_C-1:0]] <= bus.WrData;
        end
    end

    assign bus.WrFull   = wr_full;
    assign bus.WrAFull  = (free_cnt <= AFULL_C);
    assign bus.WrDNum   = wr_dnum;
    assign bus.WrOvfl   = ovfl_q;
    assign bus.FrmDrop  = drop_q;
    assign bus.RdData   = rd_data_q;
    assign bus.RdEmpty  = rd_empty;
    assign bus.RdAEmpty = (rd_dnum <= AEMPTY_C);
    assign bus.RdDNum   = rd_dnum;
    assign bus.RdUdfl   = udfl_q;
endmodule

// File: tb/tb_frame_sync_fifo.sv
// Directed bench for frame_sync_fifo: one Normal and one ShowAhead instance at depth 16.
module tb_frame_sync_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    frame_sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) nb ();
    frame_sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) sb ();

    frame_sync_fifo #(.FIFO_MODE("Normal"), .DATA_WIDTH(8), .FIFO_DEPTH(16),
                      .AFULL_GAP(4), .AEMPTY_TH(2))
        u_nrm (.SysClk(clk), .Reset_N(rst_n), .bus(nb));

    frame_sync_fifo #(.FIFO_MODE("ShowAhead"), .DATA_WIDTH(8), .FIFO_DEPTH(16),
                      .AFULL_GAP(4), .AEMPTY_TH(2))
        u_sa (.SysClk(clk), .Reset_N(rst_n), .bus(sb));

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       cm;
        logic       dc;
        logic       re;
        int         wdn;
        int         rdn;
        int         emp;
        int         rdat;
        int         drop;
        int         udfl;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic cm,
                                input logic dc, input logic re, input int wdn, input int rdn,
                                input int emp, input int rdat, input int drop, input int udfl);
        vec_t v;
        v.we = we; v.wd = wd; v.cm = cm; v.dc = dc; v.re = re;
        v.wdn = wdn; v.rdn = rdn; v.emp = emp; v.rdat = rdat; v.drop = drop; v.udfl = udfl;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nb_idle();
        nb.WrEn = 0; nb.WrData = '0; nb.WrCommit = 0; nb.WrDiscard = 0; nb.RdEn = 0;
    endtask

    task automatic sb_idle();
        sb.WrEn = 0; sb.WrData = '0; sb.WrCommit = 0; sb.WrDiscard = 0; sb.RdEn = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovfl_cnt;
        int exp_q[$];
        int popping;
        int wdn;

        nb_idle();
        sb_idle();
        step();
        step();

        chk("rst nrm WrFull", nb.WrFull, 0);
        chk("rst nrm WrAFull", nb.WrAFull, 0);
        chk("rst nrm WrDNum", nb.WrDNum, 0);
        chk("rst nrm WrOvfl", nb.WrOvfl, 0);
        chk("rst nrm FrmDrop", nb.FrmDrop, 0);
        chk("rst nrm RdData", nb.RdData, 0);
        chk("rst nrm RdEmpty", nb.RdEmpty, 1);
        chk("rst nrm RdAEmpty", nb.RdAEmpty, 1);
        chk("rst nrm RdDNum", nb.RdDNum, 0);
        chk("rst nrm RdUdfl", nb.RdUdfl, 0);
        chk("rst sa RdEmpty", sb.RdEmpty, 1);
        chk("rst sa RdData", sb.RdData, 0);
        rst_n = 1'b1;
        step();

        // Basic frame, then a frame discarded together with its last write.
        tv.push_back(mk(1, 8'h11, 0, 0, 0, 1, 0, 1, 'h00, 0, 0));
        tv.push_back(mk(1, 8'h12, 0, 0, 0, 2, 0, 1, 'h00, 0, 0));
        tv.push_back(mk(1, 8'h13, 0, 0, 0, 3, 0, 1, 'h00, 0, 0));
        tv.push_back(mk(1, 8'h14, 0, 0, 0, 4, 0, 1, 'h00, 0, 0));
        tv.push_back(mk(1, 8'h15, 0, 0, 0, 5, 0, 1, 'h00, 0, 0));
        tv.push_back(mk(0, 8'h00, 1, 0, 0, 5, 5, 0, 'h00, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 1, 4, 4, 0, 'h11, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 1, 3, 3, 0, 'h12, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 1, 2, 2, 0, 'h13, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 'h14, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 'h15, 0, 0));
        tv.push_back(mk(1, 8'h21, 0, 0, 0, 1, 0, 1, 'h15, 0, 0));
        tv.push_back(mk(1, 8'h22, 0, 0, 0, 2, 0, 1, 'h15, 0, 0));
        tv.push_back(mk(1, 8'h23, 1, 0, 0, 3, 3, 0, 'h15, 0, 0));
        tv.push_back(mk(1, 8'h31, 0, 0, 0, 4, 3, 0, 'h15, 0, 0));
        tv.push_back(mk(1, 8'h32, 0, 0, 0, 5, 3, 0, 'h15, 0, 0));
        tv.push_back(mk(1, 8'h33, 0, 0, 0, 6, 3, 0, 'h15, 0, 0));
        tv.push_back(mk(1, 8'h34, 0, 1, 0, 3, 3, 0, 'h15, 1, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 0, 3, 3, 0, 'h15, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 1, 2, 2, 0, 'h21, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 'h22, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 'h23, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 'h23, 0, 1));
        tv.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 'h23, 0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            nb.WrEn = tv[i].we; nb.WrData = tv[i].wd; nb.WrCommit = tv[i].cm;
            nb.WrDiscard = tv[i].dc; nb.RdEn = tv[i].re;
            step();
            chk($sformatf("vec%0d WrDNum", i), nb.WrDNum, tv[i].wdn);
            chk($sformatf("vec%0d RdDNum", i), nb.RdDNum, tv[i].rdn);
            chk($sformatf("vec%0d RdEmpty", i), nb.RdEmpty, tv[i].emp);
            chk($sformatf("vec%0d RdData", i), nb.RdData, tv[i].rdat);
            chk($sformatf("vec%0d FrmDrop", i), nb.FrmDrop, tv[i].drop);
            chk($sformatf("vec%0d RdUdfl", i), nb.RdUdfl, tv[i].udfl);
        end
        nb_idle();

        // ShowAhead: head word appears one edge after the commit edge.
        sb.WrEn = 1; sb.WrData = 8'hA5; sb.WrCommit = 1;
        step();
        sb_idle();
        chk("sa commit edge RdEmpty", sb.RdEmpty, 1);
        step();
        chk("sa head RdEmpty", sb.RdEmpty, 0);
        chk("sa head RdData", sb.RdData, 'hA5);
        chk("sa head RdDNum", sb.RdDNum, 1);
        sb.RdEn = 1;
        step();
        chk("sa pop RdEmpty", sb.RdEmpty, 1);
        chk("sa pop RdDNum", sb.RdDNum, 0);
        chk("sa pop RdUdfl", sb.RdUdfl, 0);
        step();
        chk("sa udfl RdUdfl", sb.RdUdfl, 1);
        chk("sa udfl RdData", sb.RdData, 'hA5);
        sb.RdEn = 0;
        step();
        chk("sa udfl clear", sb.RdUdfl, 0);
        for (int i = 0; i < 3; i++) begin
            sb.WrEn = 1; sb.WrData = 8'hB1 + 8'(i); sb.WrCommit = (i == 2);
            step();
        end
        sb_idle();
        step();
        chk("sa stream RdDNum", sb.RdDNum, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sa stream word%0d", i), sb.RdData, 'hB1 + i);
            chk($sformatf("sa stream empty%0d", i), sb.RdEmpty, 0);
            sb.RdEn = 1;
            step();
        end
        sb.RdEn = 0;
        chk("sa stream drained", sb.RdEmpty, 1);

        // Overflow: 20 writes into a 16-deep FIFO, then the commit becomes a drop.
        ovfl_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            nb.WrEn = 1; nb.WrData = 8'(i);
            step();
            ovfl_cnt += int'(nb.WrOvfl);
            if (i == 14) chk("ovf WrFull before 16th", nb.WrFull, 0);
            if (i == 15) chk("ovf WrFull after 16th", nb.WrFull, 1);
        end
        nb_idle();
        chk("ovf WrOvfl pulses", ovfl_cnt, 4);
        nb.WrCommit = 1;
        step();
        nb_idle();
        chk("ovf FrmDrop", nb.FrmDrop, 1);
        chk("ovf WrDNum", nb.WrDNum, 0);
        chk("ovf RdEmpty", nb.RdEmpty, 1);
        step();
        chk("ovf FrmDrop pulse", nb.FrmDrop, 0);
        chk("ovf RdEmpty stays", nb.RdEmpty, 1);
        nb.WrEn = 1; nb.WrData = 8'h77; nb.WrCommit = 1;
        step();
        nb_idle();
        chk("post-ovf commit RdDNum", nb.RdDNum, 1);
        chk("post-ovf commit FrmDrop", nb.FrmDrop, 0);
        nb.RdEn = 1;
        step();
        nb_idle();
        chk("post-ovf RdData", nb.RdData, 'h77);
        chk("post-ovf RdEmpty", nb.RdEmpty, 1);

        // Wrap-around: 40 three-word frames with the reader always requesting.
        for (int f = 0; f < 40; f++) begin
            for (int w = 0; w < 3; w++) begin
                nb.WrEn = 1; nb.WrData = 8'((f * 3 + w) & 255);
                nb.WrCommit = (w == 2); nb.RdEn = 1;
                popping = !nb.RdEmpty;
                exp_q.push_back((f * 3 + w) & 255);
                step();
                if (popping) chk("wrap data", nb.RdData, exp_q.pop_front());
            end
        end
        nb.WrEn = 0; nb.WrCommit = 0;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            popping = !nb.RdEmpty;
            step();
            if (popping) chk("wrap drain data", nb.RdData, exp_q.pop_front());
        end
        nb_idle();
        chk("wrap drain complete", exp_q.size(), 0);
        step();
        chk("wrap empty", nb.RdEmpty, 1);

        // Stalled reader with a full committed FIFO.
        for (int i = 0; i < 16; i++) begin
            nb.WrEn = 1; nb.WrData = 8'hC0 + 8'(i); nb.WrCommit = (i == 15);
            step();
        end
        nb_idle();
        chk("stall RdDNum", nb.RdDNum, 16);
        chk("stall WrFull", nb.WrFull, 1);
        for (int i = 0; i < 16; i++) begin
            nb.RdEn = 1;
            step();
            chk("stall data", nb.RdData, 'hC0 + i);
        end
        nb_idle();
        chk("stall drained", nb.RdEmpty, 1);

        // Thresholds: gap 4 -> WrAFull at 12; th 2 -> RdAEmpty clears at 3.
        for (int i = 0; i < 2; i++) begin
            nb.WrEn = 1; nb.WrData = 8'(i); nb.WrCommit = (i == 1);
            step();
        end
        nb_idle();
        chk("th RdDNum 2", nb.RdDNum, 2);
        chk("th RdAEmpty at 2", nb.RdAEmpty, 1);
        nb.WrEn = 1; nb.WrData = 8'h02; nb.WrCommit = 1;
        step();
        nb_idle();
        chk("th RdDNum 3", nb.RdDNum, 3);
        chk("th RdAEmpty at 3", nb.RdAEmpty, 0);
        for (int i = 0; i < 9; i++) begin
            nb.WrEn = 1; nb.WrData = 8'(i + 3); nb.WrCommit = (i == 8);
            step();
            wdn = 4 + i;
            chk($sformatf("th WrAFull at %0d", wdn), nb.WrAFull, int'(wdn >= 12));
        end
        nb_idle();
        chk("th WrDNum 12", nb.WrDNum, 12);
        nb.WrEn = 1; nb.WrData = 8'hEE; nb.RdEn = 1;
        step();
        nb_idle();
        chk("th rw WrDNum", nb.WrDNum, 12);
        chk("th rw WrAFull", nb.WrAFull, 1);
        chk("th rw RdAEmpty", nb.RdAEmpty, 0);
        chk("th rw RdDNum", nb.RdDNum, 11);

        // Asynchronous reset mid-frame clears committed and uncommitted contents.
        nb.WrEn = 1; nb.WrData = 8'h55;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst WrDNum", nb.WrDNum, 0);
        chk("async rst RdDNum", nb.RdDNum, 0);
        chk("async rst RdEmpty", nb.RdEmpty, 1);
        chk("async rst WrAFull", nb.WrAFull, 0);
        nb_idle();
        step();
        rst_n = 1'b1;
        step();
        chk("after rst WrDNum", nb.WrDNum, 0);
        chk("after rst RdData", nb.RdData, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_sync_fifo.md
# frame_sync_fifo

Single-clock, parametrised frame FIFO for the MAC datapath, e.g. between the RGMII receive parser and the packet buffer. Data is written word by word, and a frame becomes visible to the reader only when it is committed. A frame that is discarded, or that overflows, is rolled back as if it had never been written. The FIFO supports Normal and ShowAhead read modes, programmable almost-full/almost-empty thresholds, and full-range occupancy counters.

## Interface
- FIFO_MODE, "Normal": "Normal" gives registered read data one cycle after RdEn; "ShowAhead" presents the head word while RdEmpty=0.
- DATA_WIDTH, 8: word width.
- FIFO_DEPTH, 512: number of entries; must be a power of two and ≥4.
- AFULL_GAP, 16: WrAFull asserts when free entries ≤ AFULL_GAP.
- AEMPTY_TH, 4: RdAEmpty asserts when RdDNum ≤ AEMPTY_TH.
- AW_C, $clog2(FIFO_DEPTH): derived; do not override.

Ports:
- SysClk, in, 1: the single clock; all logic is on its rising edge.
- Reset_N, in, 1: asynchronous, active-low reset.
- WrEn, in, 1: write the word on WrData.
- WrData, in, DATA_WIDTH: write data.
- WrCommit, in, 1: end of a good frame; makes all uncommitted words readable.
- WrDiscard, in, 1: end of a bad frame; rolls the write pointer back to the last commit.
- WrFull, out, 1: no free entry (counts uncommitted words).
- WrAFull, out, 1: almost full.
- WrDNum, out, AW_C+1: entries in use, committed plus uncommitted, 0..FIFO_DEPTH.
- WrOvfl, out, 1: one-cycle pulse when a write is rejected because the FIFO is full.
- FrmDrop, out, 1: one-cycle pulse when a frame is rolled back.
- RdEn, in, 1: read/pop request.
- RdData, out, DATA_WIDTH: read data.
- RdEmpty, out, 1: no committed word available to the reader.
- RdAEmpty, out, 1: almost empty.
- RdDNum, out, AW_C+1: committed entries readable, 0..FIFO_DEPTH.
- RdUdfl, out, 1: one-cycle pulse when RdEn is asserted while RdEmpty=1.

## Operation
- Pointers:
  - WrPtr (write), CmPtr (commit) and RdPtr (read) are each AW_C+1 bits wide, binary, and wrap modulo 2·FIFO_DEPTH.
  - WrDNum = WrPtr−RdPtr and RdDNum = CmPtr−RdPtr, both computed modulo 2^(AW_C+1).
  - WrFull = (WrDNum==FIFO_DEPTH).
- Write:
  - WrEn & ~WrFull stores the word at WrPtr[AW_C-1:0] and increments WrPtr.
  - WrEn & WrFull drops the word, pulses WrOvfl, and sets the internal FrmErr flag.
- End of frame, evaluated after the same-cycle write:
  - WrCommit & ~WrDiscard & ~FrmErr sets CmPtr to the post-write WrPtr, so the word written in the commit cycle is included.
  - WrDiscard, or WrCommit with FrmErr set, sets WrPtr to CmPtr, pulses FrmDrop and clears FrmErr. The word written in that cycle is also dropped.
  - WrDiscard has priority over WrCommit.
  - After a rollback, FrmErr is also cleared on commit.
- Read, Normal mode:
  - RdEn & ~RdEmpty loads RdData from mem[RdPtr] and increments RdPtr.
  - RdData holds its value otherwise.
- Read, ShowAhead mode:
  - An internal head register plus a valid bit prefetches the next committed word whenever the head is empty.
  - RdEmpty = ~valid.
  - RdEn & ~RdEmpty pops the head, and the next word is fetched in the same cycle when available.
  - RdDNum counts the head word.
- RdEn & RdEmpty has no effect other than pulsing RdUdfl.
- Simultaneous write and read:
  - Legal in the same cycle, including at full and at empty.
  - When the FIFO is full, a read in the same cycle does not free a slot for that cycle's write: WrFull is evaluated from registered state.
- Flags:
  - WrAFull = (FIFO_DEPTH−WrDNum ≤ AFULL_GAP).
  - RdAEmpty = (RdDNum ≤ AEMPTY_TH).
  - All flags are decoded from registered pointers; they add no extra latency.

## Timing
- Reset values: WrFull=0, WrAFull=0, WrDNum=0, WrOvfl=0, FrmDrop=0, RdData=0, RdEmpty=1, RdAEmpty=1, RdDNum=0, RdUdfl=0. All pointers, FrmErr and the head-valid bit are 0.
- Reset is asserted asynchronously and released synchronously by the user. Assertion mid-frame discards all contents, committed and uncommitted.
- Write to WrDNum/WrFull update: 1 edge.
- Commit at edge N:
  - Normal mode: RdEmpty=0 after edge N; first RdEn at edge N+1 gives RdData valid after edge N+1.
  - ShowAhead mode: head loaded at edge N+1, so RdEmpty=0 and RdData valid after edge N+1.
- Read latency: 1 cycle in Normal mode; 0 cycles in ShowAhead mode (data is present before RdEn).
- Pulses WrOvfl, FrmDrop and RdUdfl are registered and high for the cycle after the triggering edge.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset with DEPTH=16, Normal mode:
  - Stimulus: write 5 words with no commit.
  - Required: WrDNum=5, RdEmpty=1, RdDNum=0.
  - Then WrCommit: after the next edge RdDNum=5; 5 reads return the words in order, then RdEmpty=1.
- Discard with simultaneous write:
  - Stimulus: commit 3 words, then write 4 more, the 4th together with WrDiscard.
  - Required: FrmDrop pulses, WrDNum=3, and the reader sees exactly the 3 committed words.
- Overflow, DEPTH=16:
  - Stimulus: write 20 words in one frame, then WrCommit.
  - Required: WrFull after the 16th write, WrOvfl pulses 4 times, the commit turns into a drop (FrmDrop=1), WrDNum=0, RdEmpty stays 1.
- Wrap-around:
  - Stimulus: 40 frames of 3 words at DEPTH=16 with continuous reads.
  - Required: the data sequence is intact and RdDNum reaches 16 when the reader is stalled with 16 words committed.
- ShowAhead mode:
  - Stimulus: commit 1 word, value 0xA5.
  - Required: RdData=0xA5 and RdEmpty=0 one edge after the commit.
  - Then RdEn: RdEmpty=1. A further RdEn pulses RdUdfl, and RdData is unchanged.
- Thresholds, AFULL_GAP=4, AEMPTY_TH=2:
  - WrAFull asserts at WrDNum=12.
  - RdAEmpty deasserts at RdDNum=3.
  - A simultaneous read+write at WrDNum=12 leaves both flags unchanged.
